// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB fade sequencer.
package rgb_pkg;

    localparam int PWM_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    typedef struct packed {
        logic [PWM_W-1:0] r;
        logic [PWM_W-1:0] g;
        logic [PWM_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/rgb_fade_sequencer_if.sv
// Colour command handshake between host register logic and the fade sequencer.
interface rgb_fade_sequencer_if;
    import rgb_pkg::*;

    logic cmd_valid;
    logic cmd_ready;
    rgb_t cmd_rgb;

    modport master (output cmd_valid, output cmd_rgb, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_rgb, output cmd_ready);

endinterface

// File: rtl/rgb_pwm_channel.sv
// One LED channel: current duty, single-step approach toward target and the
// registered PWM comparator.
module rgb_pwm_channel
    import rgb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt,
    input  logic             ce_fade,
    input  logic [PWM_W-1:0] target,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             pwm,
    output logic [PWM_W-1:0] duty,
    output logic             at_target
);

    logic [PWM_W-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;

    // Move one count toward the target on each fade tick; never overshoots
    always_comb begin
        duty_d = duty_q;
        if (ce_fade) begin
            if (duty_q < target) begin
                duty_d = duty_q + 1'b1;
            end else if (duty_q > target) begin
                duty_d = duty_q - 1'b1;
            end
        end
    end

    // Comparator result for the next cycle; frozen while halted
    always_comb begin
        pwm_d = pwm_q;
        if (!halt) begin
            pwm_d = (pwm_cnt < duty_q);
        end
    end

    // Duty and PWM output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm       = pwm_q;
    assign duty      = duty_q;
    assign at_target = (duty_q == target);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Tri-colour LED fade controller: shared PWM timebase, command handshake and
// the IDLE/FADE sequencer driving three duty channels.
module rgb_fade_sequencer
    import rgb_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int FADE_DIV = 64
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 halt,
    rgb_fade_sequencer_if.slave  cmd,
    output logic                 pwm_r,
    output logic                 pwm_g,
    output logic                 pwm_b,
    output logic                 busy,
    output logic                 done,
    output logic [3*PWM_W-1:0]   cur_rgb
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int              FD_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [FD_W-1:0] FD_LAST = FD_W'(FADE_DIV - 1);

    logic [PS_W-1:0]  presc_q, presc_d;
    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic [FD_W-1:0]  fdiv_q, fdiv_d;
    state_t           state_q, state_d;
    logic             busy_q;
    rgb_t             tgt_q, tgt_d;
    logic             ce, frame_tick, fade_tick, ce_fade, xfer, all_at;
    logic [2:0]       at_tgt;
    logic [PWM_W-1:0] duty_r, duty_g, duty_b;

    assign ce         = !halt && (presc_q == PS_LAST);
    assign frame_tick = ce && (cnt_q == '1);
    assign fade_tick  = frame_tick && (fdiv_q == FD_LAST);
    assign ce_fade    = fade_tick && (state_q == FADE);

    assign cmd.cmd_ready = (state_q == IDLE) && !halt;
    assign xfer          = cmd.cmd_valid && cmd.cmd_ready;
    assign all_at        = &at_tgt;

    // Free-running timebase: prescaler -> PWM counter -> frame divider
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        fdiv_d  = fdiv_q;
        if (!halt) begin
            presc_d = ce ? '0 : presc_q + 1'b1;
        end
        if (ce) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (frame_tick) begin
            fdiv_d = (fdiv_q == FD_LAST) ? '0 : fdiv_q + 1'b1;
        end
    end

    // Sequencer: accept a command in IDLE, finish once every channel sits on target
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = FADE;
                    tgt_d   = cmd.cmd_rgb;
                end
            end
            FADE: begin
                if (all_at && !halt) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Timebase, state, busy and target registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            fdiv_q  <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tgt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            fdiv_q  <= fdiv_d;
            state_q <= state_d;
            busy_q  <= (state_d == FADE);
            tgt_q   <= tgt_d;
        end
    end

    rgb_pwm_channel u_ch_r (
        .clk(clk), .rst_n(rst_n), .halt(halt), .ce_fade(ce_fade),
        .target(tgt_q.r), .pwm_cnt(cnt_q),
        .pwm(pwm_r), .duty(duty_r), .at_target(at_tgt[2])
    );

    rgb_pwm_channel u_ch_g (
        .clk(clk), .rst_n(rst_n), .halt(halt), .ce_fade(ce_fade),
        .target(tgt_q.g), .pwm_cnt(cnt_q),
        .pwm(pwm_g), .duty(duty_g), .at_target(at_tgt[1])
    );

    rgb_pwm_channel u_ch_b (
        .clk(clk), .rst_n(rst_n), .halt(halt), .ce_fade(ce_fade),
        .target(tgt_q.b), .pwm_cnt(cnt_q),
        .pwm(pwm_b), .duty(duty_b), .at_target(at_tgt[0])
    );

    assign busy    = busy_q;
    assign cur_rgb = {duty_r, duty_g, duty_b};

endmodule
